// File: rtl/memory_arbiter.sv
// Two-requester RAM arbiter: data side has priority, and a starvation guard
// forces an instruction grant after STARVE_LIMIT back-to-back data grants.
module memory_arbiter #(
  parameter int WORD_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;

  state_t        state, next_state;
  logic [CW-1:0] dstreak;
  logic          dpend;
  logic          dcomplete, icomplete;

  assign dpend = dREN | dWEN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      dstreak <= '0;
    end else begin
      state <= next_state;
      if (dcomplete) begin
        if (!iREN)
          dstreak <= '0;
        else if (dstreak != LIMIT)
          dstreak <= dstreak + 1'b1;
      end else if (icomplete) begin
        dstreak <= '0;
      end
    end
  end

  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iload      = '0;
    dload      = '0;
    err        = 1'b0;
    iwait      = iREN;
    dwait      = dpend;
    dcomplete  = 1'b0;
    icomplete  = 1'b0;
    case (state)
      IDLE: begin
        if (dpend && iREN)
          next_state = (dstreak == LIMIT) ? ISERV : DSERV;
        else if (dpend)
          next_state = DSERV;
        else if (iREN)
          next_state = ISERV;
      end
      DSERV: begin
        next_state = IDLE;
        // A withdrawn request releases the grant with strobes low and no status.
        if (dpend) begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = !dWEN;
          if (ramstate == RAM_ACCESS) begin
            dwait     = 1'b0;
            dload     = ramload;
            dcomplete = 1'b1;
          end else if (ramstate == RAM_ERROR) begin
            err = 1'b1;
          end else begin
            next_state = DSERV;
          end
        end
      end
      ISERV: begin
        next_state = IDLE;
        if (iREN) begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ramstate == RAM_ACCESS) begin
            iwait     = 1'b0;
            iload     = ramload;
            icomplete = 1'b1;
          end else if (ramstate == RAM_ERROR) begin
            err = 1'b1;
          end else begin
            next_state = ISERV;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: expected loads and grant order are queued
// when stimulus is applied and consumed when a completion is observed.
module tb_memory_arbiter;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic        CLK, RST, iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  logic [31:0] iq[$];
  logic [31:0] dq[$];
  byte         gq[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_v;
  byte         g;

  memory_arbiter #(.WORD_W(32), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
  endtask

  task automatic do_reset();
    next_cycle();
    RST = 1;
    clear_inputs();
    iq.delete(); dq.delete(); gq.delete();
    next_cycle();
    RST = 0;
  endtask

  task automatic test_reset();
    next_cycle();
    RST = 1;
    clear_inputs();
    iREN = 1;
    next_cycle();
    #1;
    tests++;
    if ({ramREN, ramWEN, ramaddr, ramstore, iload, dload, err} !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h required 0", {ramREN, ramWEN, ramaddr, ramstore, iload, dload, err});
    end
    tests++;
    if (dut.dstreak !== '0) begin
      fails++; $display("FAIL reset_dstreak: got %0d required 0", dut.dstreak);
    end
    tests++;
    if ({iwait, dwait} !== 2'b10) begin
      fails++; $display("FAIL reset_waits: got %b required 10", {iwait, dwait});
    end
    RST = 0;
    iREN = 0;
  endtask

  task automatic test_single_iread();
    do_reset();
    iREN = 1; iaddr = 32'h0000_0040;
    iq.push_back(32'h2108_0001);
    #1;
    tests++;
    if ({ramREN, iwait} !== 2'b01) begin
      fails++; $display("FAIL iread_c1: got ramREN,iwait=%b required 01", {ramREN, iwait});
    end
    next_cycle();
    ramstate = ACCESS; ramload = 32'h2108_0001;
    #1;
    tests++;
    if ({ramREN, ramWEN} !== 2'b10 || ramaddr !== 32'h40) begin
      fails++; $display("FAIL iread_grant: got ren,wen=%b addr=%h required 10 addr=00000040", {ramREN, ramWEN}, ramaddr);
    end
    tests++;
    if (iwait !== 1'b0 || iq.size() == 0) begin
      fails++; $display("FAIL iread_complete: got iwait=%b queued=%0d required iwait=0", iwait, iq.size());
    end else begin
      exp_v = iq.pop_front();
      tests++;
      if (iload !== exp_v) begin
        fails++; $display("FAIL iread_data: got %h required %h", iload, exp_v);
      end
    end
    next_cycle();
    iREN = 0; ramstate = FREE; ramload = '0;
    #1;
    tests++;
    if ({ramREN, iwait} !== 2'b00 || iload !== '0) begin
      fails++; $display("FAIL iread_idle: got ren,iwait=%b iload=%h required 00 0", {ramREN, iwait}, iload);
    end
  endtask

  task automatic test_simul_write();
    do_reset();
    iREN = 1; iaddr = 32'h44;
    dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    gq.push_back("D"); gq.push_back("I");
    iq.push_back(32'h1357_9BDF);
    #1;
    tests++;
    if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
      fails++; $display("FAIL simul_c1: got %b required 0011", {ramREN, ramWEN, iwait, dwait});
    end
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      ramstate = BUSY;
      #1;
      tests++;
      if ({ramREN, ramWEN, iwait, dwait} !== 4'b0111 || ramaddr !== 32'h100 || ramstore !== 32'hDEAD_BEEF) begin
        fails++; $display("FAIL simul_busy%0d: got flags=%b addr=%h store=%h required 0111 00000100 deadbeef", c, {ramREN, ramWEN, iwait, dwait}, ramaddr, ramstore);
      end
    end
    next_cycle();
    ramstate = ACCESS;
    #1;
    tests++;
    if (dwait !== 1'b0 || gq.size() == 0) begin
      fails++; $display("FAIL simul_dcomplete: got dwait=%b required 0", dwait);
    end else begin
      g = gq.pop_front();
      tests++;
      if (g != "D" || iwait !== 1'b1) begin
        fails++; $display("FAIL simul_order1: got side D iwait=%b required side %c iwait=1", iwait, g);
      end
    end
    next_cycle();
    dWEN = 0; ramstate = FREE;
    #1;
    tests++;
    if ({ramREN, ramWEN, iwait} !== 3'b001) begin
      fails++; $display("FAIL simul_gap: got %b required 001", {ramREN, ramWEN, iwait});
    end
    next_cycle();
    ramstate = ACCESS; ramload = 32'h1357_9BDF;
    #1;
    tests++;
    if ({ramREN, ramWEN} !== 2'b10 || ramaddr !== 32'h44 || ramstore !== '0) begin
      fails++; $display("FAIL simul_igrant: got ren,wen=%b addr=%h store=%h required 10 00000044 0", {ramREN, ramWEN}, ramaddr, ramstore);
    end
    tests++;
    if (iwait !== 1'b0 || gq.size() == 0 || iq.size() == 0) begin
      fails++; $display("FAIL simul_icomplete: got iwait=%b required 0", iwait);
    end else begin
      g = gq.pop_front();
      exp_v = iq.pop_front();
      tests++;
      if (g != "I" || iload !== exp_v) begin
        fails++; $display("FAIL simul_order2: got side I iload=%h required side %c iload=%h", iload, g, exp_v);
      end
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_starvation();
    logic chk_streak;
    do_reset();
    iREN = 1; iaddr = 32'h80;
    dREN = 1; daddr = 32'h200;
    chk_streak = 0;
    foreach (gq[k]) gq.delete(k);
    gq.push_back("D"); gq.push_back("D"); gq.push_back("D"); gq.push_back("D");
    gq.push_back("I"); gq.push_back("D");
    for (int k = 0; k < 5; k++) dq.push_back(32'h0000_0200 ^ 32'hA5A5_0000);
    iq.push_back(32'h0000_0080 ^ 32'hA5A5_0000);
    for (int c = 0; c < 40 && gq.size() > 0; c++) begin
      next_cycle();
      ramstate = (ramREN || ramWEN) ? ACCESS : FREE;
      ramload  = ramaddr ^ 32'hA5A5_0000;
      #1;
      if (chk_streak) begin
        chk_streak = 0;
        tests++;
        if (dut.dstreak !== '0) begin
          fails++; $display("FAIL starve_streak_clear: got %0d required 0", dut.dstreak);
        end
      end
      if (!dwait || !iwait) begin
        g = gq.pop_front();
        tests++;
        if ((g == "D") !== (!dwait) || (g == "I") !== (!iwait)) begin
          fails++; $display("FAIL starve_order: got iwait=%b dwait=%b required side %c", iwait, dwait, g);
        end else if (g == "D") begin
          exp_v = dq.pop_front();
          tests++;
          if (dload !== exp_v) begin
            fails++; $display("FAIL starve_dload: got %h required %h", dload, exp_v);
          end
        end else begin
          exp_v = iq.pop_front();
          tests++;
          if (iload !== exp_v || dut.dstreak !== 3'd4) begin
            fails++; $display("FAIL starve_iserv: got iload=%h streak=%0d required %h 4", iload, dut.dstreak, exp_v);
          end
          chk_streak = 1;
        end
      end
    end
    tests++;
    if (gq.size() != 0) begin
      fails++; $display("FAIL starve_timeout: got %0d grants outstanding required 0", gq.size());
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_error_retry();
    do_reset();
    dREN = 1; daddr = 32'h300;
    dq.push_back(32'hCAFE_0003);
    next_cycle();
    ramstate = ERROR; ramload = 32'h1111_1111;
    #1;
    tests++;
    if ({err, dwait, ramREN} !== 3'b111 || dload !== '0) begin
      fails++; $display("FAIL error_pulse: got err,dwait,ren=%b dload=%h required 111 0", {err, dwait, ramREN}, dload);
    end
    next_cycle();
    ramstate = FREE;
    #1;
    tests++;
    if ({err, dwait, ramREN} !== 3'b010) begin
      fails++; $display("FAIL error_after: got %b required 010", {err, dwait, ramREN});
    end
    next_cycle();
    ramstate = ACCESS; ramload = 32'hCAFE_0003;
    #1;
    tests++;
    if ({err, dwait, ramREN} !== 3'b001 || dq.size() == 0) begin
      fails++; $display("FAIL error_retry: got err,dwait,ren=%b required 001", {err, dwait, ramREN});
    end else begin
      exp_v = dq.pop_front();
      tests++;
      if (dload !== exp_v) begin
        fails++; $display("FAIL error_retry_data: got %h required %h", dload, exp_v);
      end
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_abort_withdraw();
    do_reset();
    dREN = 1; daddr = 32'h400;
    iREN = 1; iaddr = 32'h88;
    iq.push_back(32'h0BAD_F00D);
    next_cycle();
    ramstate = BUSY;
    #1;
    tests++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h400) begin
      fails++; $display("FAIL withdraw_grant: got ren=%b addr=%h required 1 00000400", ramREN, ramaddr);
    end
    next_cycle();
    dREN = 0;
    #1;
    tests++;
    if ({ramREN, ramWEN, err, dwait} !== 4'b0000 || dload !== '0) begin
      fails++; $display("FAIL withdraw_drop: got %b dload=%h required 0000 0", {ramREN, ramWEN, err, dwait}, dload);
    end
    next_cycle();
    ramstate = FREE;
    #1;
    tests++;
    if ({ramREN, err, iwait} !== 3'b001) begin
      fails++; $display("FAIL withdraw_idle: got %b required 001", {ramREN, err, iwait});
    end
    next_cycle();
    ramstate = ACCESS; ramload = 32'h0BAD_F00D;
    #1;
    tests++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h88 || iwait !== 1'b0 || iq.size() == 0) begin
      fails++; $display("FAIL withdraw_igrant: got ren=%b addr=%h iwait=%b required 1 00000088 0", ramREN, ramaddr, iwait);
    end else begin
      exp_v = iq.pop_front();
      tests++;
      if (iload !== exp_v) begin
        fails++; $display("FAIL withdraw_idata: got %h required %h", iload, exp_v);
      end
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_abort_reset();
    do_reset();
    dREN = 1; daddr = 32'h500;
    iREN = 1; iaddr = 32'h8C;
    iq.push_back(32'h7777_0008);
    next_cycle();
    ramstate = BUSY;
    #1;
    tests++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin
      fails++; $display("FAIL rstabort_grant: got ren=%b addr=%h required 1 00000500", ramREN, ramaddr);
    end
    RST = 1;
    next_cycle();
    RST = 0; dREN = 0;
    #1;
    tests++;
    if ({ramREN, ramWEN, err, dwait, iwait} !== 5'b00001 || dload !== '0) begin
      fails++; $display("FAIL rstabort_drop: got %b dload=%h required 00001 0", {ramREN, ramWEN, err, dwait, iwait}, dload);
    end
    next_cycle();
    ramstate = ACCESS; ramload = 32'h7777_0008;
    #1;
    tests++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h8C || iwait !== 1'b0 || iq.size() == 0) begin
      fails++; $display("FAIL rstabort_igrant: got ren=%b addr=%h iwait=%b required 1 0000008c 0", ramREN, ramaddr, iwait);
    end else begin
      exp_v = iq.pop_front();
      tests++;
      if (iload !== exp_v) begin
        fails++; $display("FAIL rstabort_idata: got %h required %h", iload, exp_v);
      end
    end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    CLK = 0;
    RST = 1;
    clear_inputs();
    test_reset();
    test_single_iread();
    test_simul_write();
    test_starvation();
    test_error_retry();
    test_abort_withdraw();
    test_abort_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
